// File: rtl/fifo_ast_packetizer.sv
// ---------------------------------------------------------------------------
// fifo_ast_packetizer
//
// Read-side controller for the dual-clock BRAM FIFO in the video path.
// Drains decoded BT.656 words from the FIFO read port and frames them into
// Avalon-ST video packets: one header beat followed by CFG_LINES x CFG_WORDS
// data beats. Runs entirely in the FIFO read clock domain. A 2-entry skid
// buffer absorbs the one-cycle FIFO read latency and sink backpressure.
//
// Ports
//   CLK, RST_N      FIFO read clock; asynchronous active-low reset
//   ENABLE          start / continue frames (sampled in IDLE and at frame end)
//   CFG_WORDS       words per line (0 treated as 1), latched on IDLE->HEAD
//   CFG_LINES       lines per frame (0 treated as 1), latched on IDLE->HEAD
//   FIFO_Q          FIFO read data, valid the cycle after an accepted dequeue
//   FIFO_DEQ        FIFO dequeue request (combinational)
//   FIFO_EMPTY      FIFO empty flag
//   AST_DATA/VALID/READY/SOP/EOP   Avalon-ST source, zero ready latency
//   BUSY            high whenever the FSM is not IDLE
//   FRAME_DONE      one-cycle pulse in the cycle after the EOP beat transfers
//   o_dbg_state     current FSM state (IDLE=0, HEAD=1, DATA=2)
//
// Handshake: a beat transfers on a rising edge where AST_VALID && AST_READY.
// AST_VALID never drops and AST_DATA/SOP/EOP never change while a beat is
// offered and not yet accepted. A FIFO word is accepted on a rising edge where
// FIFO_DEQ is high (FIFO_DEQ already excludes FIFO_EMPTY).
// ---------------------------------------------------------------------------
module fifo_ast_packetizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_LEN    = 12,
  parameter logic [3:0]  HDR_TYPE   = 4'h0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic [CNT_LEN-1:0]    CFG_WORDS,
  input  logic [CNT_LEN-1:0]    CFG_LINES,
  input  logic [DATA_WIDTH-1:0] FIFO_Q,
  output logic                  FIFO_DEQ,
  input  logic                  FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0] AST_DATA,
  output logic                  AST_VALID,
  input  logic                  AST_READY,
  output logic                  AST_SOP,
  output logic                  AST_EOP,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam int unsigned         TW       = 2 * CNT_LEN;
  localparam logic [CNT_LEN-1:0]    C_ONE    = CNT_LEN'(1);
  localparam logic [DATA_WIDTH-1:0] C_HEADER = DATA_WIDTH'(HDR_TYPE);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_LEN-1:0]    r_words_m1;
  logic [CNT_LEN-1:0]    r_lines_m1;
  logic [TW-1:0]         r_total;
  logic [TW-1:0]         r_fetched;
  logic [CNT_LEN-1:0]    r_col;
  logic [CNT_LEN-1:0]    r_line;
  logic [DATA_WIDTH-1:0] r_skid0;
  logic [DATA_WIDTH-1:0] r_skid1;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_frame_done;

  logic [CNT_LEN-1:0]    w_words_eff;
  logic [CNT_LEN-1:0]    w_lines_eff;
  logic                  w_pop;
  logic                  w_eop;
  logic                  w_eop_xfer;
  logic                  w_start;
  logic                  w_new_frame;
  logic                  w_room;
  logic [1:0]            w_wr_pos;

  assign w_words_eff = (CFG_WORDS == '0) ? C_ONE : CFG_WORDS;
  assign w_lines_eff = (CFG_LINES == '0) ? C_ONE : CFG_LINES;

  // A skid beat leaves only in DATA; the header never occupies the skid.
  assign w_pop      = (r_state == S_DATA) && (r_occ != 2'd0) && AST_READY;
  assign w_eop      = (r_state == S_DATA) && (r_occ != 2'd0) &&
                      (r_col == r_words_m1) && (r_line == r_lines_m1);
  assign w_eop_xfer = w_eop && AST_READY;
  assign w_start    = (r_state == S_IDLE) && ENABLE;

  // Counters restart whenever a header is about to be presented
  // (from IDLE or back-to-back from DATA).
  assign w_new_frame = (w_next_state == S_HEAD) && (r_state != S_HEAD);

  // Words held plus the word still in the FIFO read pipeline, less the one
  // leaving this cycle, must leave a free slot for a new request.
  assign w_room   = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_wr_pos = r_occ - {1'b0, w_pop};

  assign FIFO_DEQ = ((r_state == S_HEAD) || (r_state == S_DATA)) && !FIFO_EMPTY &&
                    (r_fetched < r_total) && w_room;

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (ENABLE) w_next_state = S_HEAD;
      S_HEAD: if (AST_READY) w_next_state = S_DATA;
      S_DATA: if (w_eop_xfer) w_next_state = ENABLE ? S_HEAD : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Output stage: header in HEAD, skid entry 0 in DATA, zeros in IDLE.
  always_comb begin
    AST_DATA  = '0;
    AST_VALID = 1'b0;
    AST_SOP   = 1'b0;
    AST_EOP   = 1'b0;
    case (r_state)
      S_HEAD: begin
        AST_DATA  = C_HEADER;
        AST_VALID = 1'b1;
        AST_SOP   = 1'b1;
      end
      S_DATA: begin
        AST_DATA  = r_skid0;
        AST_VALID = (r_occ != 2'd0);
        AST_EOP   = w_eop;
      end
      default: ;
    endcase
  end

  assign BUSY        = (r_state != S_IDLE);
  assign FRAME_DONE  = r_frame_done;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_words_m1   <= '0;
      r_lines_m1   <= '0;
      r_total      <= '0;
      r_fetched    <= '0;
      r_col        <= '0;
      r_line       <= '0;
      r_skid0      <= '0;
      r_skid1      <= '0;
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_words_m1 <= w_words_eff - C_ONE;
        r_lines_m1 <= w_lines_eff - C_ONE;
        r_total    <= TW'(w_words_eff) * TW'(w_lines_eff);
      end

      if (w_new_frame)   r_fetched <= '0;
      else if (FIFO_DEQ) r_fetched <= r_fetched + TW'(1);

      r_inflight <= FIFO_DEQ;

      // Column/line position of the beat in skid entry 0.
      if (w_new_frame || w_eop_xfer) begin
        r_col  <= '0;
        r_line <= '0;
      end else if (w_pop) begin
        if (r_col == r_words_m1) begin
          r_col  <= '0;
          r_line <= r_line + C_ONE;
        end else begin
          r_col <= r_col + C_ONE;
        end
      end

      // Shift first; an arriving word then lands behind whatever remains.
      if (w_pop) r_skid0 <= r_skid1;
      if (r_inflight) begin
        if (w_wr_pos == 2'd0) r_skid0 <= FIFO_Q;
        else                  r_skid1 <= FIFO_Q;
      end

      r_occ        <= r_occ - {1'b0, w_pop} + {1'b0, r_inflight};
      r_frame_done <= w_eop_xfer;
    end
  end

endmodule

// File: tb/tb_fifo_ast_packetizer.sv
`timescale 1ns/1ps
module tb_fifo_ast_packetizer;

  localparam int DW = 32;
  localparam int CL = 12;
  localparam logic [3:0]    HDR      = 4'h5;
  localparam logic [DW-1:0] HDR_WORD = {28'h0, HDR};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [CL-1:0] cfg_words = '0;
  logic [CL-1:0] cfg_lines = '0;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_deq;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] ast_data;
  logic          ast_valid;
  logic          ast_ready = 1'b0;
  logic          ast_sop;
  logic          ast_eop;
  logic          busy;
  logic          frame_done;
  logic [1:0]    dbg_state;

  fifo_ast_packetizer #(.DATA_WIDTH(DW), .CNT_LEN(CL), .HDR_TYPE(HDR)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable),
    .CFG_WORDS(cfg_words), .CFG_LINES(cfg_lines),
    .FIFO_Q(fifo_q), .FIFO_DEQ(fifo_deq), .FIFO_EMPTY(fifo_empty),
    .AST_DATA(ast_data), .AST_VALID(ast_valid), .AST_READY(ast_ready),
    .AST_SOP(ast_sop), .AST_EOP(ast_eop), .BUSY(busy), .FRAME_DONE(frame_done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW+1:0] exp_q[$];      // {sop, eop, data}
  logic [DW-1:0] fifo_mem[$];   // FIFO contents model
  logic [DW-1:0] next_word = 1; // next value pushed into the FIFO
  logic [DW-1:0] exp_next  = 1; // next value expected on a data beat
  bit fifo_block = 0;
  bit feed_mode  = 0;
  bit stall_mode = 0;
  int ready_mode = 0;           // 0: always ready, 1: 1,0,0 pattern, 2: random
  int cyc = 0;

  bit m_busy = 0;
  int m_w = 1, m_l = 1, m_deq_frame = 0, m_data_xfer = 0;

  logic s_valid, s_sop, s_eop, s_deq, s_done, s_busy;
  logic [DW-1:0] s_data;
  bit prev_stall = 0, prev_eop_xfer = 0, prev_restart = 0;
  logic [DW+1:0] prev_beat = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int eff(input logic [CL-1:0] x);
    return (x == '0) ? 1 : int'(x);
  endfunction

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem.push_back(next_word);
      next_word++;
    end
  endtask

  // Expected packet: header, then m_w*m_l consecutive FIFO words, EOP on last.
  task automatic build_frame();
    int n;
    n = m_w * m_l;
    exp_q.push_back({1'b1, 1'b0, HDR_WORD});
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({1'b0, (k == n - 1), exp_next});
      exp_next++;
    end
    m_deq_frame = 0;
    m_data_xfer = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic xfer;
    logic eop_xfer;
    logic [DW+1:0] e;
    case (ready_mode)
      0:       ast_ready = 1'b1;
      1:       ast_ready = ((cyc % 3) == 0);
      default: ast_ready = 1'($urandom_range(0, 1));
    endcase
    if (feed_mode && fifo_mem.size() < 4 && $urandom_range(0, 3) != 0) push_words(1);
    if (stall_mode) fifo_block = ($urandom_range(0, 3) == 0);
    fifo_empty = (fifo_mem.size() == 0) || fifo_block;

    @(negedge clk);
    s_valid = ast_valid; s_sop = ast_sop; s_eop = ast_eop; s_data = ast_data;
    s_deq = fifo_deq; s_done = frame_done; s_busy = busy;

    check("busy", s_busy, m_busy);
    check("frame_done", s_done, prev_eop_xfer);
    if (!m_busy) check("idle_valid", s_valid, 0);
    if (prev_stall) begin
      check("hold_valid", s_valid, 1);
      check("hold_beat", {s_sop, s_eop, s_data}, prev_beat);
    end
    if (prev_restart) check("b2b_header", {s_valid, s_sop}, 2'b11);
    if (fifo_empty) check("deq_on_empty", s_deq, 0);

    xfer = s_valid && ast_ready;
    eop_xfer = 1'b0;
    if (xfer) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", {s_sop, s_eop, s_data}, e);
        if (!e[DW+1]) m_data_xfer++;
        eop_xfer = e[DW];
      end
    end
    if (s_deq) begin
      check("over_read", m_deq_frame < m_w * m_l, 1);
      m_deq_frame++;
    end
    if (m_busy) check("buffered_le2", (m_deq_frame - m_data_xfer) <= 2, 1);

    prev_restart = 0;
    if (!m_busy && enable) begin
      m_w = eff(cfg_words);
      m_l = eff(cfg_lines);
      build_frame();
      m_busy = 1;
    end else if (m_busy && eop_xfer) begin
      if (enable) begin
        build_frame();
        prev_restart = 1;
      end else begin
        m_busy = 0;
      end
    end
    prev_stall    = s_valid && !ast_ready;
    prev_beat     = {s_sop, s_eop, s_data};
    prev_eop_xfer = eop_xfer;

    @(posedge clk);
    #1;
    cyc++;
    if (s_deq && fifo_mem.size() != 0) fifo_q = fifo_mem.pop_front();
    else fifo_q = $urandom;
  endtask

  // Hold ENABLE for 'hold' cycles, then run until the model is idle.
  task automatic run_frames(input int hold);
    bit done;
    done = 0;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == hold) enable = 1'b0;
      step();
      if (i >= hold && !m_busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    enable = 1'b0;
    check("frame_complete", done, 1);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, ast_valid, 0);
    check({tag, "_sop"}, ast_sop, 0);
    check({tag, "_eop"}, ast_eop, 0);
    check({tag, "_data"}, ast_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_deq"}, fifo_deq, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic clear_model();
    fifo_mem.delete();
    exp_q.delete();
    exp_next = next_word;
    m_busy = 0;
    m_deq_frame = 0;
    m_data_xfer = 0;
    prev_stall = 0;
    prev_eop_xfer = 0;
    prev_restart = 0;
    fifo_block = 0;
  endtask

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // ---- reset ----
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // ---- basic frame with exact timing ----
    cfg_words = 12'd4; cfg_lines = 12'd2; ready_mode = 0;
    push_words(8);
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    check("t1_hdr_valid", s_valid, 1);
    check("t1_hdr_sop", s_sop, 1);
    check("t1_hdr_data", s_data, HDR_WORD);
    check("t1_first_deq", s_deq, 1);
    step();
    check("t1_bubble", s_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t1_valid", s_valid, 1);
      check("t1_data", s_data, k + 1);
      check("t1_eop", s_eop, (k == 7));
    end
    step();
    check("t1_done", s_done, 1);
    check("t1_busy", s_busy, 0);
    check("t1_fifo_left", fifo_mem.size(), 0);

    // ---- backpressure ----
    ready_mode = 1;
    push_words(8);
    run_frames(1);
    check("t2_fifo_left", fifo_mem.size(), 0);
    check("t2_deq_count", m_deq_frame, 8);

    // ---- underflow: 3 words, 10-cycle stall, 5 words ----
    ready_mode = 0;
    push_words(3);
    enable = 1'b1;
    step();
    enable = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (fifo_mem.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("t3_drained", ok, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 4) check("t3_stall_valid", s_valid, 0);
    end
    push_words(5);
    run_frames(0);

    // ---- over-read guard ----
    push_words(12);
    run_frames(1);
    check("t4_fifo_left", fifo_mem.size(), 4);
    check("t4_deq_count", m_deq_frame, 8);

    // ---- continuous frames ----
    push_words(12);
    run_frames(12);
    check("t5_fifo_left", fifo_mem.size(), 0);

    // ---- reset mid-frame ----
    push_words(8);
    enable = 1'b1;
    step();
    enable = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_data_xfer >= 3) begin
        ok = 1;
        break;
      end
    end
    check("t6_reached_beat3", ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(posedge clk);
    clear_model();
    #2;
    rst_n = 1'b1;
    cfg_words = 12'd3; cfg_lines = 12'd2;
    push_words(6);
    run_frames(1);
    check("t6_fifo_left", fifo_mem.size(), 0);

    // ---- randomized frames ----
    feed_mode = 1; stall_mode = 1; ready_mode = 2;
    for (int r = 0; r < 10; r++) begin
      cfg_words = CL'($urandom_range(0, 5));
      cfg_lines = CL'($urandom_range(0, 3));
      run_frames($urandom_range(1, 25));
    end
    feed_mode = 0; stall_mode = 0;

    check("final_exp_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
